// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers six displayed digits (BCD), decimal points and
// per-digit pattern-error flags from a scanned 7-segment seg/sel bus.
//
// state  | meaning
// WAIT   | no single digit selected; stability count held at 0
// SETTLE | one digit selected, counting consecutive identical samples
// HELD   | current dwell already captured; waiting for the bus to change
module seg_scan_capture #(
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [5:0]  sel,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic [5:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);
  localparam logic [TCW-1:0] TO_MAX     = TCW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      s_seg;
  logic [5:0]      s_sel;
  logic [5:0]      nsel;
  logic [7:0]      nseg;
  logic [13:0]     key, key_q;
  logic            sel_ok;
  logic [SCW-1:0]  cnt, cnt_nxt;
  logic            capture;
  logic [5:0]      seen;
  logic [TCW-1:0]  tcnt, tcnt_nxt;
  logic [3:0]      dec_code;
  logic            dec_err;

  assign nsel   = s_sel ^ {6{SEL_ACTIVE_LOW}};
  assign nseg   = s_seg ^ {8{SEG_ACTIVE_LOW}};
  assign key    = {nsel, nseg};
  assign sel_ok = (nsel != 6'd0) && ((nsel & (nsel - 6'd1)) == 6'd0);

  // Sample the raw bus and keep the previous normalised sample; reset parks
  // the sampler at the "nothing selected" level so a partial dwell is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      s_sel <= {6{SEL_ACTIVE_LOW}};
      s_seg <= {8{SEG_ACTIVE_LOW}};
      key_q <= '0;
    end else begin
      s_sel <= sel;
      s_seg <= seg;
      key_q <= key;
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, stability count and capture strobe (capture fires in the
  // cycle whose sample brings the identical-sample count to STABLE_CYCLES)
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!sel_ok) begin
      state_nxt = WAIT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        WAIT: begin
          state_nxt = SETTLE;
          cnt_nxt   = SCW'(1);
        end
        SETTLE: begin
          if (key == key_q) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == STABLE_MAX) begin
              capture   = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            cnt_nxt = SCW'(1);
          end
        end
        HELD: begin
          if (key != key_q) begin
            state_nxt = SETTLE;
            cnt_nxt   = SCW'(1);
          end
        end
        default: begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Segment pattern to digit code; blank reads as F, anything unknown as E
  always_comb begin
    dec_err  = 1'b0;
    dec_code = 4'hE;
    case (nseg[6:0])
      7'h3F:        dec_code = 4'd0;
      7'h06:        dec_code = 4'd1;
      7'h5B:        dec_code = 4'd2;
      7'h4F:        dec_code = 4'd3;
      7'h66:        dec_code = 4'd4;
      7'h6D:        dec_code = 4'd5;
      7'h7D:        dec_code = 4'd6;
      7'h07, 7'h27: dec_code = 4'd7;
      7'h7F:        dec_code = 4'd8;
      7'h6F, 7'h67: dec_code = 4'd9;
      7'h00:        dec_code = 4'hF;
      default:      dec_err  = 1'b1;
    endcase
  end

  assign tcnt_nxt = capture ? '0 : ((tcnt == TO_MAX) ? tcnt : tcnt + 1'b1);

  // Capture into the selected digit slot, frame tracking and stale timeout;
  // a capture in the expiry cycle takes priority over raising stale
  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= 24'hFFFFFF;
      dp          <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b1;
      seen        <= '0;
      tcnt        <= '0;
    end else begin
      frame_valid <= 1'b0;
      tcnt        <= tcnt_nxt;
      if (capture) begin
        for (int k = 0; k < 6; k++) begin
          if (nsel[k]) begin
            digits[4*k +: 4] <= dec_code;
            dp[k]            <= nseg[7];
            digit_err[k]     <= dec_err;
          end
        end
        stale <= 1'b0;
        if ((seen | nsel) == 6'h3F) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen | nsel;
        end
      end else if (tcnt_nxt == TO_MAX) begin
        stale <= 1'b1;
        seen  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: table-driven digit vectors, hand-written
// multi-cycle sequences, and a random phase against a behavioural model.
module tb_seg_scan_capture;

  localparam int STABLE = 16;
  localparam int TMO    = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg = 8'hFF;
  logic [5:0]  sel = 6'h3F;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  seg_scan_capture #(
    .SEL_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .sel        (sel),
    .digits     (digits),
    .dp         (dp),
    .digit_err  (digit_err),
    .frame_valid(frame_valid),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model: run length of identical valid pin samples
  logic [23:0] m_digits;
  logic [5:0]  m_dp, m_err, m_seen;
  logic        m_fv, m_stale;
  int          m_since, m_run;
  logic [13:0] m_last, m_pend_key;
  bit          m_last_ok, m_pend;
  int          edge_n = 0;
  int          m_last_cap_edge = 0;
  int          fv_cnt = 0;

  logic [6:0]  seg_pat [10];

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    int         hold;
    int         idx;
    logic [3:0] code;
    logic       dpv;
    logic       err;
    int         fv;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] decode_ref(input logic [6:0] p);
    if (p == 7'h00) return {1'b0, 4'hF};
    if (p == 7'h27) return {1'b0, 4'd7};
    if (p == 7'h67) return {1'b0, 4'd9};
    for (int i = 0; i < 10; i++)
      if (p == seg_pat[i]) return {1'b0, 4'(i)};
    return {1'b1, 4'hE};
  endfunction

  function automatic bit one_active(input logic [5:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) if (!s[i]) n++;
    return n == 1;
  endfunction

  task automatic model_edge();
    int          idx;
    logic [4:0]  d;
    logic [13:0] cur;
    bit          ok;
    edge_n++;
    if (rst) begin
      m_digits = 24'hFFFFFF; m_dp = '0; m_err = '0; m_seen = '0;
      m_fv = 1'b0; m_stale = 1'b1; m_since = 0; m_run = 0;
      m_last_ok = 0; m_pend = 0; m_last = '0; m_pend_key = '0;
      return;
    end
    m_fv = 1'b0;
    if (m_pend) begin
      idx = 0;
      for (int k = 0; k < 6; k++) if (!m_pend_key[8+k]) idx = k;
      d = decode_ref(~m_pend_key[6:0]);
      m_digits[4*idx +: 4] = d[3:0];
      m_err[idx]  = d[4];
      m_dp[idx]   = ~m_pend_key[7];
      m_seen[idx] = 1'b1;
      if (m_seen == 6'h3F) begin
        m_fv = 1'b1;
        m_seen = '0;
      end
      m_since = 0;
      m_stale = 1'b0;
      m_last_cap_edge = edge_n;
    end else if (m_since < TMO) begin
      m_since++;
      if (m_since == TMO) begin
        m_stale = 1'b1;
        m_seen = '0;
      end
    end
    cur = {sel, seg};
    ok  = one_active(sel);
    if (!ok) m_run = 0;
    else if (m_last_ok && cur == m_last) m_run++;
    else m_run = 1;
    m_last = cur;
    m_last_ok = ok;
    m_pend = (m_run == STABLE);
    m_pend_key = cur;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (frame_valid) fv_cnt++;
    chk("model", {digits, dp, digit_err, frame_valid, stale},
                 {m_digits, m_dp, m_err, m_fv, m_stale});
  endtask

  task automatic hold(input logic [5:0] s, input logic [7:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) cyc();
  endtask

  initial begin
    int fv0, waited, r;
    bit got;
    seg_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vt[0]  = '{6'h3E, 8'hC0, 20, 0, 4'h0, 1'b0, 1'b0, 0};
    vt[1]  = '{6'h3E, 8'hF9, 20, 0, 4'h1, 1'b0, 1'b0, 0};
    vt[2]  = '{6'h3D, 8'hA4, 20, 1, 4'h2, 1'b0, 1'b0, 0};
    vt[3]  = '{6'h3B, 8'hB0, 20, 2, 4'h3, 1'b0, 1'b0, 0};
    vt[4]  = '{6'h37, 8'h99, 20, 3, 4'h4, 1'b0, 1'b0, 0};
    vt[5]  = '{6'h2F, 8'h92, 20, 4, 4'h5, 1'b0, 1'b0, 0};
    vt[6]  = '{6'h1F, 8'h82, 20, 5, 4'h6, 1'b0, 1'b0, 1};
    vt[7]  = '{6'h3B, 8'hF6, 20, 2, 4'hE, 1'b0, 1'b1, 0};
    vt[8]  = '{6'h3B, 8'hFF, 20, 2, 4'hF, 1'b0, 1'b0, 0};
    vt[9]  = '{6'h3D, 8'h40, 20, 1, 4'h0, 1'b1, 1'b0, 0};
    vt[10] = '{6'h37, 8'hD8, 20, 3, 4'h7, 1'b0, 1'b0, 0};
    vt[11] = '{6'h2F, 8'h98, 20, 4, 4'h9, 1'b0, 1'b0, 0};

    rst = 1'b1;
    repeat (3) cyc();
    chk("reset digits", digits, 24'hFFFFFF);
    chk("reset dp", dp, 6'h00);
    chk("reset err", digit_err, 6'h00);
    chk("reset stale", stale, 1'b1);
    chk("reset fv", frame_valid, 1'b0);
    rst = 1'b0;

    // first capture needs 16 samples; updated on edge 17
    sel = 6'h3E; seg = 8'hC0;
    repeat (16) cyc();
    chk("lat16 digit0", digits[3:0], 4'hF);
    cyc();
    chk("lat17 digit0", digits[3:0], 4'h0);
    chk("lat17 stale", stale, 1'b0);
    repeat (3) cyc();

    for (int i = 0; i < 12; i++) begin
      fv0 = fv_cnt;
      hold(vt[i].sel, vt[i].seg, vt[i].hold);
      chk($sformatf("vec%0d code", i), digits[4*vt[i].idx +: 4], vt[i].code);
      chk($sformatf("vec%0d dp", i), dp[vt[i].idx], vt[i].dpv);
      chk($sformatf("vec%0d err", i), digit_err[vt[i].idx], vt[i].err);
      chk($sformatf("vec%0d stale", i), stale, 1'b0);
      chk($sformatf("vec%0d fv pulses", i), 64'(fv_cnt - fv0), 64'(vt[i].fv));
      if (i == 6) chk("scan digits", digits, 24'h654321);
    end
    chk("table digits", digits, 24'h697F01);

    // glitch: two selects active, then seg changing every 10 cycles
    fv0 = fv_cnt;
    hold(6'h3C, 8'hC0, 30);
    hold(6'h3E, 8'hC0, 10);
    hold(6'h3E, 8'hF9, 10);
    hold(6'h3E, 8'hA4, 10);
    hold(6'h3E, 8'hB0, 10);
    hold(6'h3E, 8'h99, 10);
    chk("glitch digits", digits, 24'h697F01);
    chk("glitch fv", 64'(fv_cnt - fv0), 64'd0);
    chk("glitch stale", stale, 1'b1);

    // timeout: three captures, then idle until stale
    hold(6'h37, 8'hC0, 20);
    hold(6'h2F, 8'hC0, 20);
    hold(6'h1F, 8'hC0, 20);
    sel = 6'h3F; seg = 8'hFF;
    got = 0; waited = 0;
    while (!got && waited < 200) begin
      cyc();
      waited++;
      if (stale) got = 1;
    end
    chk("stale seen", got, 1'b1);
    chk("stale delay", 64'(edge_n - m_last_cap_edge), 64'(TMO));
    fv0 = fv_cnt;
    hold(6'h3E, 8'hF9, 20);
    hold(6'h3D, 8'hA4, 20);
    hold(6'h3B, 8'hB0, 20);
    hold(6'h37, 8'h99, 20);
    hold(6'h2F, 8'h92, 20);
    chk("post-timeout fv early", 64'(fv_cnt - fv0), 64'd0);
    hold(6'h1F, 8'h82, 20);
    chk("post-timeout fv", 64'(fv_cnt - fv0), 64'd1);

    // reset at count 10 of a dwell, bus left unchanged
    hold(6'h37, 8'hF8, 10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (16) cyc();
    chk("rst dwell digits", digits, 24'hFFFFFF);
    chk("rst dwell stale", stale, 1'b1);
    chk("rst dwell dp", dp, 6'h00);
    cyc();
    chk("rst dwell capture", digits[15:12], 4'h7);
    chk("rst dwell stale clr", stale, 1'b0);

    // capture lands exactly on the expiry cycle: capture wins
    hold(6'h3E, 8'hC0, 20);
    hold(6'h3F, 8'hFF, 30);
    hold(6'h3D, 8'hF9, 20);
    chk("expiry race stale", stale, 1'b0);
    chk("expiry race digit1", digits[7:4], 4'h1);

    // random dwells against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) sel = ~(6'b000001 << $urandom_range(0, 5));
      else       sel = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        seg = ~{1'($urandom), seg_pat[$urandom_range(0, 9)]};
      else
        seg = 8'($urandom);
      repeat ($urandom_range(1, 24)) cyc();
      if (n % 50 == 49) hold(6'h3F, 8'hFF, 60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
